// File: rtl/if_id_fetch_queue.sv
// Fetch-to-decode decoupling FIFO carrying {pc, inst} pairs under valid/ready.
// Flush (branch redirect) empties the queue; empty reads present pc=0 / NOP.
module if_id_fetch_queue #(
   parameter int unsigned          DEPTH  = 2,
   parameter int unsigned          PC_W   = 64,
   parameter int unsigned          INST_W = 32,
   parameter logic [INST_W-1:0]    NOP    = 32'h00000013
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [PC_W-1:0]            in_pc,
   input  logic [INST_W-1:0]          in_inst,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [PC_W-1:0]            out_pc,
   output logic [INST_W-1:0]          out_inst,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [PC_W-1:0]   pc_mem_q   [DEPTH];
   logic [INST_W-1:0] inst_mem_q [DEPTH];

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q,  count_d;

   logic enq, deq;

   assign in_ready  = (count_q != CW'(DEPTH));
   assign out_valid = (count_q != '0);
   assign enq       = in_valid & in_ready;
   assign deq       = out_valid & out_ready;
   assign count     = count_q;

   always_comb begin
      out_pc   = '0;
      out_inst = NOP;
      if (out_valid) begin
         out_pc   = pc_mem_q[rd_ptr_q];
         out_inst = inst_mem_q[rd_ptr_q];
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (enq) wr_ptr_d = wr_ptr_q + AW'(1);
         if (deq) rd_ptr_d = rd_ptr_q + AW'(1);
         unique case ({enq, deq})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is deliberately unreset; a flush suppresses the write as well.
   always_ff @(posedge clk) begin
      if (enq && !flush) begin
         pc_mem_q[wr_ptr_q]   <= in_pc;
         inst_mem_q[wr_ptr_q] <= in_inst;
      end
   end

endmodule
